// File: rtl/sram22_bist_pkg.sv
// March C- element tables and shared constants for the sram22 BIST controller.
// Pure definitions: no logic, no latency.
package sram22_bist_pkg;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} bist_state_t;

    localparam int NUM_CMDS   = 5120;
    localparam int FAIL_CNT_W = 16;

    // E3/E4 walk the array top-down; every other element walks bottom-up.
    function automatic logic elem_down(input march_elem_t e);
        return (e == E3) || (e == E4);
    endfunction

    // E0 and E5 carry one op; E1..E4 are (read, write) pairs indexed by op.
    function automatic logic op_is_last(input march_elem_t e, input logic op);
        return (e == E0) || (e == E5) || op;
    endfunction

    function automatic logic op_is_write(input march_elem_t e, input logic op);
        return (e == E0) || ((e != E5) && op);
    endfunction

    // 0 selects the background, 1 its complement.
    function automatic logic op_pattern(input march_elem_t e, input logic op);
        case (e)
            E1, E3:  return op;
            E2, E4:  return ~op;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram22_bist_addr_gen.sv
// Up/down march address counter with load-to-start, advance enable and last flag.
// Address is registered; load/advance take effect on the next edge.
module sram22_bist_addr_gen #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_down,
    input  logic                  i_adv,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_down;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_addr <= i_down ? '1 : '0;
            r_down <= i_down;
        end else if (i_adv) begin
            r_addr <= r_down ? r_addr - ONE : r_addr + ONE;
        end
    end

    assign o_addr = r_addr;
    assign o_last = r_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/sram22_bist.sv
// March C- BIST initiator for the sram22 macro; all outputs registered.
// First command one cycle after start; done 5122 edges after start is sampled.
module sram22_bist
    import sram22_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 9,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    WMASK_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BG          = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_fail,
    output logic [ADDR_WIDTH-1:0]  o_fail_addr,
    output logic [FAIL_CNT_W-1:0]  o_fail_count,
    output logic                   o_sram_rstb,
    output logic                   o_sram_ce,
    output logic                   o_sram_we,
    output logic [WMASK_WIDTH-1:0] o_sram_wmask,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    output logic [DATA_WIDTH-1:0]  o_sram_din,
    input  logic [DATA_WIDTH-1:0]  i_sram_dout
);

    localparam logic [FAIL_CNT_W-1:0] CNT_ONE = {{(FAIL_CNT_W-1){1'b0}}, 1'b1};

    bist_state_t           r_state, w_state_nxt;
    march_elem_t           r_elem, w_elem_nxt;
    logic                  r_op, w_op_nxt;
    logic                  w_issue, w_ag_load, w_ag_down, w_ag_adv, w_ag_last;
    logic [ADDR_WIDTH-1:0] w_ag_addr;
    logic                  w_accept, w_finish, w_mis, w_wr;
    logic [DATA_WIDTH-1:0] w_pat;

    logic                   r_busy, r_done, r_fail, r_rstb, r_ce, r_we;
    logic [ADDR_WIDTH-1:0]  r_fail_addr, r_pipe_addr;
    logic [FAIL_CNT_W-1:0]  r_fail_count;
    logic [WMASK_WIDTH-1:0] r_wmask;
    logic [DATA_WIDTH-1:0]  r_din, r_cmd_exp, r_pipe_exp;
    logic                   r_pipe_vld;

    sram22_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_ag_load),
        .i_down (w_ag_down),
        .i_adv  (w_ag_adv),
        .o_addr (w_ag_addr),
        .o_last (w_ag_last)
    );

    // The (elem, op, addr) pointer names the command currently on the bus;
    // each RUN cycle steps it and registers the command it lands on.
    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_op_nxt    = r_op;
        w_issue     = 1'b0;
        w_ag_load   = 1'b0;
        w_ag_down   = 1'b0;
        w_ag_adv    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_elem_nxt  = E0;
                    w_op_nxt    = 1'b0;
                    w_issue     = 1'b1;
                    w_ag_load   = 1'b1;
                    w_ag_down   = elem_down(E0);
                end
            end
            S_RUN: begin
                w_issue = 1'b1;
                if (!op_is_last(r_elem, r_op)) begin
                    w_op_nxt = 1'b1;
                end else if (!w_ag_last) begin
                    w_op_nxt = 1'b0;
                    w_ag_adv = 1'b1;
                end else if (r_elem == E5) begin
                    w_issue     = 1'b0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_elem_nxt = march_elem_t'(r_elem + 3'd1);
                    w_op_nxt   = 1'b0;
                    w_ag_load  = 1'b1;
                    w_ag_down  = elem_down(w_elem_nxt);
                end
            end
            S_DRAIN: begin
                if (!r_pipe_vld) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_finish = (r_state == S_DRAIN) && !r_pipe_vld;
    assign w_wr     = w_issue && op_is_write(w_elem_nxt, w_op_nxt);
    assign w_pat    = op_pattern(w_elem_nxt, w_op_nxt) ? ~BG : BG;
    assign w_mis    = r_pipe_vld && (i_sram_dout != r_pipe_exp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_elem  <= E0;
            r_op    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_op    <= w_op_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rstb    <= 1'b0;
            r_ce      <= 1'b0;
            r_we      <= 1'b0;
            r_wmask   <= '0;
            r_din     <= '0;
            r_cmd_exp <= '0;
        end else begin
            r_rstb    <= 1'b1;
            r_ce      <= w_issue;
            r_we      <= w_wr;
            r_wmask   <= w_wr ? '1 : '0;
            r_din     <= w_wr ? w_pat : '0;
            r_cmd_exp <= w_pat;
        end
    end

    // Loaded on the edge the macro samples a read; compared against dout next edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_vld  <= 1'b0;
            r_pipe_exp  <= '0;
            r_pipe_addr <= '0;
        end else begin
            r_pipe_vld  <= r_ce && !r_we;
            r_pipe_exp  <= r_cmd_exp;
            r_pipe_addr <= w_ag_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_count <= '0;
        end else if (w_accept) begin
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_count <= '0;
        end else begin
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_mis) begin
                r_fail <= 1'b1;
                if (!r_fail) r_fail_addr <= r_pipe_addr;
                if (r_fail_count != '1) r_fail_count <= r_fail_count + CNT_ONE;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_fail       = r_fail;
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_count = r_fail_count;
    assign o_sram_rstb  = r_rstb;
    assign o_sram_ce    = r_ce;
    assign o_sram_we    = r_we;
    assign o_sram_wmask = r_wmask;
    assign o_sram_addr  = w_ag_addr;
    assign o_sram_din   = r_din;

endmodule

// File: tb/tb_sram22_bist.sv
// Bench for sram22_bist: two instances (BG=0 and BG=AAAA..), behavioural macros
// with injectable stuck-at faults, and a March C- command/fault reference model.
module tb_sram22_bist;
    import sram22_bist_pkg::*;

    localparam int          AW    = 9;
    localparam int          DW    = 64;
    localparam int          MW    = 8;
    localparam int          DEPTH = 512;
    localparam logic [63:0] BG1   = 64'hAAAA_AAAA_AAAA_AAAA;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] wmask;
        logic [DW-1:0] din;
    } cmd_t;

    logic clk = 1'b0;
    logic rst, start;
    always #5 clk = ~clk;

    logic          d0_busy, d0_done, d0_fail, d0_rstb, d0_ce, d0_we;
    logic [AW-1:0] d0_fail_addr, d0_addr;
    logic [15:0]   d0_fail_count;
    logic [MW-1:0] d0_wmask;
    logic [DW-1:0] d0_din, d0_dout;
    logic          d1_busy, d1_done, d1_fail, d1_rstb, d1_ce, d1_we;
    logic [AW-1:0] d1_fail_addr, d1_addr;
    logic [15:0]   d1_fail_count;
    logic [MW-1:0] d1_wmask;
    logic [DW-1:0] d1_din, d1_dout;

    sram22_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .BG(64'h0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(d0_busy), .o_done(d0_done), .o_fail(d0_fail),
        .o_fail_addr(d0_fail_addr), .o_fail_count(d0_fail_count),
        .o_sram_rstb(d0_rstb), .o_sram_ce(d0_ce), .o_sram_we(d0_we),
        .o_sram_wmask(d0_wmask), .o_sram_addr(d0_addr), .o_sram_din(d0_din),
        .i_sram_dout(d0_dout)
    );

    sram22_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .BG(BG1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(d1_busy), .o_done(d1_done), .o_fail(d1_fail),
        .o_fail_addr(d1_fail_addr), .o_fail_count(d1_fail_count),
        .o_sram_rstb(d1_rstb), .o_sram_ce(d1_ce), .o_sram_we(d1_we),
        .o_sram_wmask(d1_wmask), .o_sram_addr(d1_addr), .o_sram_din(d1_din),
        .i_sram_dout(d1_dout)
    );

    // ---------------- behavioural macros with stuck-at faults on read ----------------
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    int            f_addr [2];
    logic [DW-1:0] f_s1   [2];
    logic [DW-1:0] f_s0   [2];

    function automatic logic [DW-1:0] bytemask(input logic [MW-1:0] m);
        logic [DW-1:0] bm;
        for (int b = 0; b < MW; b++) bm[8*b +: 8] = {8{m[b]}};
        return bm;
    endfunction

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [DW-1:0] s1,
                                             input logic [DW-1:0] s0);
        return (v | s1) & ~s0;
    endfunction

    always @(posedge clk) begin
        if (d0_ce) begin
            if (d0_we) mem0[d0_addr] <= (mem0[d0_addr] & ~bytemask(d0_wmask)) | (d0_din & bytemask(d0_wmask));
            else d0_dout <= (int'(d0_addr) == f_addr[0]) ? faulty(mem0[d0_addr], f_s1[0], f_s0[0]) : mem0[d0_addr];
        end
        if (d1_ce) begin
            if (d1_we) mem1[d1_addr] <= (mem1[d1_addr] & ~bytemask(d1_wmask)) | (d1_din & bytemask(d1_wmask));
            else d1_dout <= (int'(d1_addr) == f_addr[1]) ? faulty(mem1[d1_addr], f_s1[1], f_s0[1]) : mem1[d1_addr];
        end
    end

    // ---------------- reference model: March C- as tables ----------------
    int   el_nops [6]    = '{1, 2, 2, 2, 2, 1};
    bit   el_down [6]    = '{0, 0, 0, 1, 1, 0};
    bit   el_wr   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit   el_pat  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    cmd_t          exp_c   [2][NUM_CMDS];
    logic [DW-1:0] exp_dat [2][NUM_CMDS];

    task automatic build_exp(input int k, input logic [DW-1:0] bg);
        int n;
        int a;
        logic [DW-1:0] d;
        n = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = el_down[e] ? DEPTH - 1 - i : i;
                for (int o = 0; o < el_nops[e]; o++) begin
                    d = el_pat[e][o] ? ~bg : bg;
                    exp_dat[k][n] = d;
                    if (el_wr[e][o]) exp_c[k][n] = '{1'b1, AW'(a), 8'hFF, d};
                    else             exp_c[k][n] = '{1'b0, AW'(a), 8'h00, 64'h0};
                    n++;
                end
            end
        end
    endtask

    task automatic ref_faults(input int k, input int fa, input logic [DW-1:0] s1, input logic [DW-1:0] s0,
                              output int cnt, output int first);
        logic [DW-1:0] rm [DEPTH];
        logic [DW-1:0] v;
        int a;
        cnt   = 0;
        first = 0;
        for (int n = 0; n < NUM_CMDS; n++) begin
            a = int'(exp_c[k][n].addr);
            if (exp_c[k][n].we) rm[a] = exp_c[k][n].din;
            else begin
                v = (a == fa) ? faulty(rm[a], s1, s0) : rm[a];
                if (v !== exp_dat[k][n]) begin
                    if (cnt == 0) first = a;
                    cnt++;
                end
            end
        end
    endtask

    // ---------------- command monitor ----------------
    cmd_t obs_c [2][NUM_CMDS];
    int   n_cmd [2];
    int   n_wr  [2];
    int   n_err [2];
    bit   mon_en;

    task automatic mon_one(input int k, input logic ce, input cmd_t c);
        if (ce) begin
            if (n_cmd[k] < NUM_CMDS) begin
                obs_c[k][n_cmd[k]] = c;
                if (c !== exp_c[k][n_cmd[k]]) n_err[k]++;
            end else begin
                n_err[k]++;
            end
            n_cmd[k]++;
            if (c.we) n_wr[k]++;
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            for (int k = 0; k < 2; k++) begin
                n_cmd[k] = 0;
                n_wr[k]  = 0;
                n_err[k] = 0;
            end
        end else begin
            mon_one(0, d0_ce, '{d0_we, d0_addr, d0_wmask, d0_din});
            mon_one(1, d1_ce, '{d1_we, d1_addr, d1_wmask, d1_din});
        end
    end

    // ---------------- stimulus helpers ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic launch(input bit hold);
        @(posedge clk); #1 mon_en = 0;
        @(posedge clk); #1 start = 1; mon_en = 1;
        @(posedge clk); #1 if (!hold) start = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 6000 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (d0_done) lat = k;
        end
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 2; k++) begin
            f_addr[k] = -1;
            f_s1[k]   = '0;
            f_s0[k]   = '0;
        end
    endtask

    task automatic pick_fault(input int k);
        int b;
        b         = $urandom_range(0, DW - 1);
        f_addr[k] = $urandom_range(0, DEPTH - 1);
        f_s1[k]   = '0;
        f_s0[k]   = '0;
        if ($urandom_range(0, 1) == 1) f_s1[k][b] = 1'b1;
        else                           f_s0[k][b] = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; start = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({d0_busy, d0_done, d0_fail, d0_fail_addr, d0_fail_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_status: got busy=%b done=%b fail=%b addr=%h cnt=%h want all 0",
                     d0_busy, d0_done, d0_fail, d0_fail_addr, d0_fail_count);
        end
        tests_run++;
        if ({d0_ce, d0_we, d0_wmask, d0_addr, d0_din, d0_rstb} !== '0) begin
            tests_failed++;
            $display("FAIL reset_cmd: got ce=%b we=%b wmask=%h addr=%h din=%h rstb=%b want all 0",
                     d0_ce, d0_we, d0_wmask, d0_addr, d0_din, d0_rstb);
        end
        rst = 0;
        @(posedge clk); #1;
        tests_run++;
        if (d0_rstb !== 1'b1 || d0_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rstb=%b busy=%b want rstb=1 busy=0", d0_rstb, d0_busy);
        end
    endtask

    task automatic test_clean();
        int lat;
        cmd_t want;
        clear_faults();
        launch(0);
        wait_done(lat);
        tests_run++;
        if (lat !== 5122 || d0_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_latency: got %0d busy=%b want 5122 busy=0", lat, d0_busy);
        end
        tests_run++;
        if (n_cmd[0] !== 5120 || n_wr[0] !== 2560) begin
            tests_failed++;
            $display("FAIL clean_counts: got ce=%0d writes=%0d want 5120 2560", n_cmd[0], n_wr[0]);
        end
        tests_run++;
        if (n_err[0] !== 0 || n_err[1] !== 0) begin
            tests_failed++;
            $display("FAIL clean_sequence: got %0d/%0d bad commands want 0/0", n_err[0], n_err[1]);
        end
        tests_run++;
        if (d0_fail !== 1'b0 || d0_fail_count !== 16'd0 || d1_fail !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_result: got fail=%b cnt=%0d fail1=%b want 0 0 0", d0_fail, d0_fail_count, d1_fail);
        end
        want = '{1'b1, 9'h1FF, 8'hFF, 64'h0};
        tests_run++;
        if (obs_c[0][511] !== want) begin
            tests_failed++;
            $display("FAIL e0_last: got %h want %h", obs_c[0][511], want);
        end
        want = '{1'b0, 9'h1FF, 8'h00, 64'h0};
        tests_run++;
        if (obs_c[0][2560] !== want) begin
            tests_failed++;
            $display("FAIL e3_first: got %h want %h", obs_c[0][2560], want);
        end
        want = '{1'b1, 9'h000, 8'hFF, 64'h5555_5555_5555_5555};
        tests_run++;
        if (obs_c[1][513] !== want) begin
            tests_failed++;
            $display("FAIL e1_write_bg: got %h want %h", obs_c[1][513], want);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (d0_done !== 1'b1 || d0_busy !== 1'b0 || d0_ce !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_hold: got done=%b busy=%b ce=%b want 1 0 0", d0_done, d0_busy, d0_ce);
        end
    endtask

    task automatic test_faults(input bit fixed);
        int lat, cnt, first;
        if (fixed) begin
            clear_faults();
            f_addr[0]   = 'h0A3;
            f_s1[0][5]  = 1'b1;
        end else begin
            pick_fault(0);
        end
        pick_fault(1);
        launch(0);
        wait_done(lat);
        tests_run++;
        if (lat !== 5122) begin
            tests_failed++;
            $display("FAIL fault_latency: got %0d want 5122", lat);
        end
        if (fixed) begin
            tests_run++;
            if (d0_fail !== 1'b1 || d0_fail_addr !== 9'h0A3 || d0_fail_count !== 16'd3) begin
                tests_failed++;
                $display("FAIL stuck_0a3: got fail=%b addr=%h cnt=%0d want 1 0a3 3",
                         d0_fail, d0_fail_addr, d0_fail_count);
            end
        end else begin
            ref_faults(0, f_addr[0], f_s1[0], f_s0[0], cnt, first);
            tests_run++;
            if (d0_fail !== (cnt != 0) || int'(d0_fail_addr) !== first || int'(d0_fail_count) !== cnt) begin
                tests_failed++;
                $display("FAIL rand_fault0: got fail=%b addr=%h cnt=%0d want %b %h %0d",
                         d0_fail, d0_fail_addr, d0_fail_count, cnt != 0, first, cnt);
            end
        end
        ref_faults(1, f_addr[1], f_s1[1], f_s0[1], cnt, first);
        tests_run++;
        if (d1_fail !== (cnt != 0) || int'(d1_fail_addr) !== first || int'(d1_fail_count) !== cnt) begin
            tests_failed++;
            $display("FAIL rand_fault1: got fail=%b addr=%h cnt=%0d want %b %h %0d",
                     d1_fail, d1_fail_addr, d1_fail_count, cnt != 0, first, cnt);
        end
    endtask

    task automatic test_mid_reset();
        int lat, fa;
        clear_faults();
        fa          = $urandom_range(0, 200);
        f_addr[0]   = fa;
        f_s1[0][$urandom_range(0, 63)] = 1'b1;
        launch(0);
        repeat (999) @(posedge clk);
        #1;
        tests_run++;
        if (d0_fail_count !== 16'd1 || int'(d0_fail_addr) !== fa || d0_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_before: got cnt=%0d addr=%h busy=%b want 1 %h 1", d0_fail_count, d0_fail_addr, d0_busy, fa);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        tests_run++;
        if ({d0_ce, d0_busy, d0_done, d0_fail_count, d0_rstb} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got ce=%b busy=%b done=%b cnt=%0d rstb=%b want all 0",
                     d0_ce, d0_busy, d0_done, d0_fail_count, d0_rstb);
        end
        clear_faults();
        launch(0);
        wait_done(lat);
        tests_run++;
        if (lat !== 5122 || d0_fail !== 1'b0 || n_err[0] !== 0 || n_cmd[0] !== NUM_CMDS) begin
            tests_failed++;
            $display("FAIL mid_rerun: got lat=%0d fail=%b bad=%0d ce=%0d want 5122 0 0 %0d",
                     lat, d0_fail, n_err[0], n_cmd[0], NUM_CMDS);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        clear_faults();
        launch(1);
        wait_done(lat);
        tests_run++;
        if (lat !== 5122 || n_cmd[0] !== 5120 || n_err[0] !== 0) begin
            tests_failed++;
            $display("FAIL held_run: got lat=%0d ce=%0d bad=%0d want 5122 5120 0", lat, n_cmd[0], n_err[0]);
        end
        @(posedge clk); #1;
        start = 0;
        tests_run++;
        if (d0_busy !== 1'b1 || d0_done !== 1'b0 || d0_ce !== 1'b1 || d0_we !== 1'b1 || d0_addr !== 9'h000) begin
            tests_failed++;
            $display("FAIL held_restart: got busy=%b done=%b ce=%b we=%b addr=%h want 1 0 1 1 000",
                     d0_busy, d0_done, d0_ce, d0_we, d0_addr);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 5122 || d0_fail !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_run: got lat=%0d fail=%b want 5122 0", lat, d0_fail);
        end
    endtask

    initial begin
        rst    = 1;
        start  = 0;
        mon_en = 0;
        clear_faults();
        build_exp(0, 64'h0);
        build_exp(1, BG1);
        test_reset();
        test_clean();
        test_faults(1'b1);
        test_faults(1'b0);
        test_faults(1'b0);
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram22_bist.md
Name: sram22_bist

Overview:
- March C- built-in self-test controller that acts as the initiator for a single-port sram22 macro with 512 words × 64 bits and byte write mask.
- It drives the macro's clk-domain command port (ce/we/wmask/addr/din) and checks registered read data.
- It reports pass/fail plus first failing address.
- It sits beside the macro in the macro wrapper; the wrapper muxes functional traffic onto the macro when busy=0.

Parameters:
- ADDR_WIDTH, 9, macro address width; depth = 1<<ADDR_WIDTH.
- DATA_WIDTH, 64, macro word width.
- WMASK_WIDTH, 8, macro write-mask width; one bit per DATA_WIDTH/WMASK_WIDTH bits.
- BG, 64'h0, data background; "0" pattern = BG, "1" pattern = ~BG.

Ports:
- clk  in  1  clock; shared with the macro.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin test; sampled only in IDLE.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start or rst.
- fail  out  1  sticky; at least one read mismatch seen this run.
- fail_addr  out  ADDR_WIDTH  address of first mismatching read.
- fail_count  out  16  number of mismatching reads; saturates at 16'hFFFF.
- sram_rstb  out  1  macro reset bar; 0 while rst, else 1.
- sram_ce  out  1  macro chip enable.
- sram_we  out  1  macro write enable.
- sram_wmask  out  WMASK_WIDTH  macro write mask; all ones on every write.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro write data.
- sram_dout  in  DATA_WIDTH  macro read data; valid the cycle after a read command is sampled.

Behaviour:
- Reset:
  - All outputs are registered.
  - On rst: state=IDLE; busy=0, done=0, fail=0, fail_addr=0, fail_count=0.
  - sram_ce=0, sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0, sram_rstb=0.
- Reset mid-run: same result. The macro sees ce=0 from the edge where rst is sampled. No partial-element resume.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE -> RUN:
  - On start=1, the next edge sets busy=1, done=0, and clears fail, fail_addr and fail_count.
  - The first command appears on sram_* in the cycle after start is sampled.
  - start while busy is ignored.
- Elements in RUN. ⇑ means address 0..511 and ⇓ means 511..0. Ops run back-to-back with ce=1 every cycle and no idle cycles.
  - E0: ⇑(w0).
  - E1: ⇑(r0,w1).
  - E2: ⇑(r1,w0).
  - E3: ⇓(r0,w1).
  - E4: ⇓(r1,w0).
  - E5: ⇑(r0).
- Commands:
  - Read: we=0, wmask=0, din=0.
  - Write: we=1, wmask all ones, din=pattern.
  - Address changes only after the last op of the element at that address.
- Command count: 512 + 4×1024 + 512 = 5120 consecutive command cycles.
- Compare:
  - A one-deep pipeline register holds {valid, expected, addr} for each issued read.
  - In the next cycle, sram_dout != expected is a mismatch.
  - The first mismatch of a run loads fail_addr. Later mismatches do not change it.
  - Each mismatch increments fail_count, saturating.
  - Simultaneous pipeline compare and new command issue is the normal steady state.
- DRAIN:
  - Entered after the 5120th command. Sets ce=0 and we=0.
  - Performs the final E5 read compare.
  - The next edge sets busy=0 and done=1.
  - Result: busy falls and done rises 5122 edges after the edge that sampled start.
- Wrap-around: element transitions at address 511 (⇑) or 0 (⇓). The ⇓ counter does not underflow past 0.

Decomposition:
- Package sram22_bist_pkg holds:
  - enum march_elem_t (E0..E5).
  - direction per element.
  - op lists (r/w, pattern bit) per element.
  - localparam NUM_CMDS = 5120.
  - FAIL_CNT_W = 16.
- One sub-module: sram22_bist_addr_gen. It is an up/down ADDR_WIDTH counter with load-to-start, advance enable and a last-address flag. The main FSM, compare pipeline and result registers stay in sram22_bist.

Test Plan:
- Fault-free behavioural macro, BG=0, start pulsed once:
  - Exactly 5120 cycles with sram_ce=1.
  - 2560 writes, each with wmask=8'hFF.
  - done=1 and busy=0 at edge 5122; fail=0, fail_count=0.
- Stuck-at-1 injected on bit 5 of word 0x0A3:
  - fail=1, fail_addr=9'h0A3, fail_count=3 (E1, E3 and E5 r0 reads fail).
- Order check:
  - E3's first command is a read at addr 9'h1FF.
  - E0's last command is a write at 9'h1FF, with din=64'h0.
- BG=64'hAAAA_AAAA_AAAA_AAAA: E1 writes carry din=64'h5555_5555_5555_5555; fault-free run gives fail=0.
- rst asserted at cycle 1000 of a run:
  - The next edge shows ce=0, busy=0, done=0, fail_count=0.
  - A fresh start then completes clean in 5122 edges.
- start held high for the whole run: ignored while busy. After done, a new run begins only on the next start sampled in IDLE, which clears done.
